// File: rtl/code_sequencer_pkg.sv
// Shared definitions for the pulse-code transmit sequencer.
package code_sequencer_pkg;

  localparam int unsigned DEF_CODE_MAX_LEN = 64;
  localparam int unsigned DEF_CHIP_W       = 16;
  localparam int unsigned DEF_PRI_W        = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/code_sequencer_chip_timer.sv
// Chip-length and pulse-period counters for code_sequencer.
module chip_timer
  import code_sequencer_pkg::*;
#(
  parameter int unsigned CHIP_W = DEF_CHIP_W,
  parameter int unsigned PRI_W  = DEF_PRI_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              tx_en,
  input  logic [CHIP_W-1:0] chip_last,
  input  logic [PRI_W-1:0]  period_last,
  output logic              chip_end,
  output logic              period_end
);

  logic [CHIP_W-1:0] chip_cnt;
  logic [PRI_W-1:0]  period_cnt;

  // Chip counter: runs only while transmitting, wraps at the chip boundary.
  always_ff @(posedge clk) begin
    if (!rst || clear || !tx_en) begin
      chip_cnt <= '0;
    end else if (chip_cnt == chip_last) begin
      chip_cnt <= '0;
    end else begin
      chip_cnt <= chip_cnt + CHIP_W'(1);
    end
  end

  // Period counter: free-runs through TX and GAP, wraps only at the period end.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      period_cnt <= '0;
    end else if (period_cnt == period_last) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PRI_W'(1);
    end
  end

  assign chip_end   = tx_en && (chip_cnt == chip_last);
  assign period_end = !clear && (period_cnt == period_last);

endmodule

// File: rtl/code_sequencer.sv
// Phase-code pulse burst sequencer: emits a latched chip code as a train of
// pulses with a programmable chip length and pulse repetition interval.
module code_sequencer
  import code_sequencer_pkg::*;
#(
  parameter int unsigned CODE_MAX_LEN = DEF_CODE_MAX_LEN,
  parameter int unsigned CHIP_W       = DEF_CHIP_W,
  parameter int unsigned PRI_W        = DEF_PRI_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            stop,
  input  logic [CODE_MAX_LEN-1:0]         cfg_code,
  input  logic [$clog2(CODE_MAX_LEN):0]   cfg_code_len,
  input  logic [CHIP_W-1:0]               cfg_chip_len,
  input  logic [PRI_W-1:0]                cfg_pri,
  input  logic [15:0]                     cfg_num_pulses,
  output logic                            code,
  output logic                            sinc,
  output logic                            pulse_start,
  output logic                            busy,
  output logic                            done,
  output logic [15:0]                     pulse_count
);

  localparam int unsigned LEN_W = $clog2(CODE_MAX_LEN) + 1;
  localparam int unsigned IDX_W = (CODE_MAX_LEN > 1) ? $clog2(CODE_MAX_LEN) : 1;
  localparam int unsigned NL_W  = CHIP_W + LEN_W;
  localparam int unsigned P_W   = (PRI_W > NL_W) ? PRI_W : NL_W;

  tx_state_e               state;
  logic [CODE_MAX_LEN-1:0] code_q;
  logic [LEN_W-1:0]        len_q;
  logic [CHIP_W-1:0]       chip_q;
  logic [PRI_W-1:0]        pri_q;
  logic [15:0]             num_q;
  logic [IDX_W-1:0]        chip_idx;
  logic                    stop_pend;

  logic [LEN_W-1:0]  n_chips;
  logic [CHIP_W-1:0] chip_last;
  logic [NL_W-1:0]   tx_len;
  logic [P_W-1:0]    period;
  logic [PRI_W-1:0]  period_last;
  logic              last_chip;
  logic              last_pulse;
  logic [15:0]       pc_next;
  logic              chip_end;
  logic              period_end;

  // Derived timing from the latched configuration: clamped chip count,
  // chip length, and effective period (never shorter than the pulse itself).
  always_comb begin
    n_chips = len_q;
    if (len_q == '0) begin
      n_chips = LEN_W'(1);
    end else if (len_q > LEN_W'(CODE_MAX_LEN)) begin
      n_chips = LEN_W'(CODE_MAX_LEN);
    end
    chip_last   = (chip_q == '0) ? '0 : chip_q - CHIP_W'(1);
    tx_len      = NL_W'(n_chips) * (NL_W'(chip_last) + NL_W'(1));
    period      = (P_W'(pri_q) > P_W'(tx_len)) ? P_W'(pri_q) : P_W'(tx_len);
    period_last = PRI_W'(period - P_W'(1));
    last_chip   = (chip_idx == IDX_W'(n_chips - LEN_W'(1)));
    last_pulse  = (num_q != 16'd0) && (pulse_count == num_q);
    pc_next     = (&pulse_count) ? pulse_count : pulse_count + 16'd1;
  end

  chip_timer #(
    .CHIP_W (CHIP_W),
    .PRI_W  (PRI_W)
  ) u_chip_timer (
    .clk         (clk),
    .rst         (rst),
    .clear       (state == IDLE),
    .tx_en       (state == TX),
    .chip_last   (chip_last),
    .period_last (period_last),
    .chip_end    (chip_end),
    .period_end  (period_end)
  );

  // Burst FSM, configuration latch and strobes.
  // A pulse ends the burst at its last chip, so the final pulse has no trailing gap;
  // when the period equals the pulse length, period_end lands on the last chip
  // and the next pulse follows directly in TX.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      code_q      <= '0;
      len_q       <= '0;
      chip_q      <= '0;
      pri_q       <= '0;
      num_q       <= '0;
      chip_idx    <= '0;
      stop_pend   <= 1'b0;
      pulse_start <= 1'b0;
      done        <= 1'b0;
      pulse_count <= '0;
    end else begin
      pulse_start <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            code_q      <= cfg_code;
            len_q       <= cfg_code_len;
            chip_q      <= cfg_chip_len;
            pri_q       <= cfg_pri;
            num_q       <= cfg_num_pulses;
            chip_idx    <= '0;
            stop_pend   <= 1'b0;
            pulse_count <= 16'd1;
            pulse_start <= 1'b1;
            state       <= TX;
          end
        end
        TX: begin
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (chip_end) begin
            if (last_chip) begin
              chip_idx <= '0;
              if (last_pulse || stop_pend || stop) begin
                state     <= IDLE;
                done      <= 1'b1;
                stop_pend <= 1'b0;
              end else if (period_end) begin
                pulse_start <= 1'b1;
                pulse_count <= pc_next;
              end else begin
                state <= GAP;
              end
            end else begin
              chip_idx <= chip_idx + IDX_W'(1);
            end
          end
        end
        GAP: begin
          if (stop) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (period_end) begin
            state       <= TX;
            pulse_start <= 1'b1;
            pulse_count <= pc_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign code = (state == TX) ? code_q[chip_idx] : 1'b0;
  assign sinc = (state == TX);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_code_sequencer.sv
// Directed self-checking bench for code_sequencer.
module tb_code_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [63:0] cfg_code = '0;
  logic [6:0]  cfg_code_len = '0;
  logic [15:0] cfg_chip_len = '0;
  logic [31:0] cfg_pri = '0;
  logic [15:0] cfg_num_pulses = '0;
  logic        code, sinc, pulse_start, busy, done;
  logic [15:0] pulse_count;

  int tests = 0;
  int fails = 0;

  code_sequencer #(
    .CODE_MAX_LEN (64),
    .CHIP_W       (16),
    .PRI_W        (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .cfg_code       (cfg_code),
    .cfg_code_len   (cfg_code_len),
    .cfg_chip_len   (cfg_chip_len),
    .cfg_pri        (cfg_pri),
    .cfg_num_pulses (cfg_num_pulses),
    .code           (code),
    .sinc           (sinc),
    .pulse_start    (pulse_start),
    .busy           (busy),
    .done           (done),
    .pulse_count    (pulse_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_cfg(input logic [63:0] c_code, input int c_len, input int c_chip,
                          input int c_pri, input int c_num);
    cfg_code       = c_code;
    cfg_code_len   = 7'(c_len);
    cfg_chip_len   = 16'(c_chip);
    cfg_pri        = 32'(c_pri);
    cfg_num_pulses = 16'(c_num);
  endtask

  // Start a burst at the next edge T; returns right after T so the next
  // negedge is cycle T+1.
  task automatic kick(input bit with_stop);
    @(negedge clk);
    start = 1'b1;
    stop  = with_stop;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Finite burst checked cycle by cycle against a period/offset model.
  // At cycle 3 the configuration is scrambled and start re-asserted; neither
  // may affect the running burst.
  task automatic run_burst(input string name, input logic [63:0] c_code, input int c_len,
                           input int c_chip, input int c_pri, input int c_num,
                           input bit with_stop);
    int n, l, nl, p, last, k, o;
    bit in_tx;
    n  = (c_len < 1) ? 1 : ((c_len > 64) ? 64 : c_len);
    l  = (c_chip < 1) ? 1 : c_chip;
    nl = n * l;
    p  = (c_pri > nl) ? c_pri : nl;
    last = (c_num - 1) * p + nl;
    load_cfg(c_code, c_len, c_chip, c_pri, c_num);
    kick(with_stop);
    for (int c = 1; c <= last + 3; c++) begin
      @(negedge clk);
      k = (c - 1) / p;
      o = (c - 1) % p;
      in_tx = (c <= last) && (o < nl);
      check($sformatf("%s sinc c%0d", name, c), 32'(sinc), 32'(in_tx));
      check($sformatf("%s code c%0d", name, c), 32'(code), in_tx ? 32'(c_code[o / l]) : 32'd0);
      check($sformatf("%s pstart c%0d", name, c), 32'(pulse_start), 32'(in_tx && o == 0));
      check($sformatf("%s busy c%0d", name, c), 32'(busy), 32'(c <= last));
      check($sformatf("%s done c%0d", name, c), 32'(done), 32'(c == last + 1));
      check($sformatf("%s pcount c%0d", name, c), 32'(pulse_count),
            (c <= last) ? 32'(k + 1) : 32'(c_num));
      if (c == 3) begin
        load_cfg(~c_code, 1, 9, 5, 9);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    int done_cnt;

    // Reset state, plus stop while idle must do nothing
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst sinc", 32'(sinc), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst pcount", 32'(pulse_count), 32'd0);
    check("rst code", 32'(code), 32'd0);
    check("rst pstart", 32'(pulse_start), 32'd0);
    rst  = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    check("idle stop busy", 32'(busy), 32'd0);
    check("idle stop done", 32'(done), 32'd0);

    // Barker-13, gapped pulses
    run_burst("barker", 64'h1F35, 13, 4, 100, 3, 1'b0);
    // PRI shorter than pulse: continuous sinc; start+stop together, start wins
    run_burst("shortpri", 64'hA5, 4, 4, 10, 2, 1'b1);
    // Zero lengths clamp to one one-cycle chip
    run_burst("minlen", 64'h1, 0, 0, 3, 3, 1'b0);
    // Over-long code length clamps to 64 chips, back-to-back pulses
    run_burst("maxlen", 64'hDEAD_BEEF_0123_4567, 70, 1, 0, 2, 1'b0);

    // Continuous mode, stop during chip 2 of pulse 5 (pulse 5 starts at c81,
    // chip 2 covers c87..c89, pulse ends c92)
    load_cfg(64'hB, 4, 3, 20, 0);
    kick(1'b0);
    done_cnt = 0;
    for (int c = 1; c <= 110; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (c == 86) check("cont pcount p5", 32'(pulse_count), 32'd5);
      if (c == 92) check("cont sinc last chip", 32'(sinc), 32'd1);
      if (c == 93) begin
        check("cont sinc after", 32'(sinc), 32'd0);
        check("cont busy after", 32'(busy), 32'd0);
        check("cont done", 32'(done), 32'd1);
      end
      if (c == 100) check("cont pcount end", 32'(pulse_count), 32'd5);
      stop = (c == 87);
    end
    stop = 1'b0;
    check("cont done count", 32'(done_cnt), 32'd1);

    // Continuous mode, stop in the gap of pulse 2 (gap c33..c40)
    kick(1'b0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 36) begin
        check("gapstop busy before", 32'(busy), 32'd1);
        check("gapstop sinc before", 32'(sinc), 32'd0);
      end
      if (c == 37) begin
        check("gapstop busy", 32'(busy), 32'd0);
        check("gapstop done", 32'(done), 32'd1);
        check("gapstop pcount", 32'(pulse_count), 32'd2);
      end
      stop = (c == 36);
    end
    stop = 1'b0;

    // Reset mid-TX, then a clean burst
    load_cfg(64'h1F35, 13, 4, 100, 3);
    kick(1'b0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 11) begin
        check("midrst sinc", 32'(sinc), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst pcount", 32'(pulse_count), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        rst = 1'b1;
      end else if (c > 11) begin
        check($sformatf("postrst done c%0d", c), 32'(done), 32'd0);
        check($sformatf("postrst busy c%0d", c), 32'(busy), 32'd0);
      end
      if (c == 10) rst = 1'b0;
    end
    run_burst("afterrst", 64'h6, 3, 2, 9, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
